lsu_mem_master: RTL and testbench
=================================

Name: lsu_mem_master

Overview:
Load/store initiator that drives the data port of the core's dual-port word RAM on behalf of the execute stage. It takes byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests over a valid/ready handshake and converts them to the RAM's word-wide accesses. The RAM has no byte enables, so sub-word stores use a read-modify-write sequence. Results return on a valid/ready response channel with sign/zero extension applied.

Parameters:
DW, 32, data width; fixed at 32, other values unsupported.
MEM_DEPTH, 65536, RAM depth in words; must match the RAM instance.
AW, $clog2(MEM_DEPTH), word address width (derived, do not override).

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous assert, active-low
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&&ready
req_we  in  1  1=store, 0=load
req_addr  in  32  byte address
req_size  in  2  0=byte, 1=half, 2=word, 3=illegal
req_unsigned  in  1  zero-extend loads (LBU/LHU)
req_wdata  in  32  store data, right-aligned
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when valid&&ready
rsp_rdata  out  32  load result, extended; 0 for stores/errors
rsp_err  out  1  illegal size or misaligned access
wen  out  1  RAM write enable
w_addr_o  out  AW  RAM write word address
w_data_o  out  32  RAM write data
ren  out  1  RAM read enable
r_addr_o  out  AW  RAM read word address
r_data_i  in  32  RAM read data, combinational from r_addr_o

Behaviour:
- FSM states: IDLE, RD, WR, RESP. Async reset -> IDLE. All registers clear: rsp_rdata=0, rsp_err=0, latched request=0.
- req_ready = (state==IDLE). After reset, req_ready=1 and every other output is 0.
- ren, wen, and the addresses/data are decoded from state and the latched request. When inactive, the addresses and data are 0.
- Word address = latched req_addr[AW+1:2]. Address bits above AW+1 are ignored. Byte offset off = req_addr[1:0].
- IDLE, on accept, latch the request and branch:
  - size==3 -> RESP with err=1.
  - misaligned (see feature) -> RESP with err=1.
  - load -> RD.
  - SW -> WR.
  - SB/SH -> RD.
- RD: ren=1, r_addr_o=word address. Capture r_data_i at the clock edge.
  - Load -> RESP. rdata = selected lane (byte at off*8; half at off[1]*16), sign-extended unless req_unsigned.
  - SB/SH -> WR. merge buffer = captured word with the addressed lane replaced by req_wdata[7:0] or [15:0].
- WR: wen=1, w_addr_o=word address, w_data_o=req_wdata (SW) or the merge buffer. wen is high for exactly one cycle. -> RESP.
- RESP: rsp_valid=1, with rsp_rdata/rsp_err held stable. If rsp_ready -> IDLE, so req_ready=1 on the next cycle. Otherwise hold indefinitely.
- Latency, accept edge = cycle 0: load rsp_valid in cycle 2; SW in cycle 2; SB/SH in cycle 3; error in cycle 1. No pipelining; one outstanding request max.
- Error responses never assert ren or wen.
- Reset mid-operation: abort immediately to IDLE. The request is discarded and no response is issued. A write not yet in WR never reaches the RAM.
- rsp_valid never drops without rsp_ready. Request inputs are ignored outside IDLE.

Optional Feature:
Macro LSU_MISALIGN_TRAP_EN.
- Defined: LH/LHU/SH with off[0]=1, or LW/SW with off!=0, responds err=1 and skips the RAM access.
- Undefined: misaligned offsets are forced to alignment (half uses off[1] with off[0] ignored; word uses off=0) and the access proceeds normally. rsp_err is asserted only for size==3.

Test Plan:
- SW 0x100 data 0xDEADBEEF then LW 0x100 -> wen one cycle at word 0x40 with 0xDEADBEEF; load rsp_rdata=0xDEADBEEF, rsp_valid 2 cycles after accept, err=0.
- SB 0x101 data 0x000000AA over 0xDEADBEEF -> ren cycle 1, wen cycle 2 with w_data_o=0xDEADAAEF, rsp_valid cycle 3.
- Then LB 0x101 -> 0xFFFFFFAA; LBU 0x101 -> 0x000000AA; LH 0x102 -> 0xFFFFDEAD; LHU 0x102 -> 0x0000DEAD.
- LW 0x102 -> with LSU_MISALIGN_TRAP_EN: rsp_err=1 in cycle 1, ren never high. Without the macro: reads word 0x40, rsp_rdata=0xDEADAAEF, err=0. A size=3 request -> err=1 in both builds.
- Hold rsp_ready=0 for 3 cycles after a load -> rsp_valid and rsp_rdata stable, req_ready=0, no RAM activity. Raise rsp_ready -> req_ready=1 next cycle.
- Pulse rst_n low while in RD of SH 0x104 -> wen never asserted, word 0x41 unchanged, rsp_valid=0, req_ready=1 after release.

Source files
------------

// File: rtl/lsu_mem_master.sv
// Load/store initiator that turns byte-addressed requests into word RAM accesses (read-modify-write for SB/SH).
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses return rsp_err instead of being force-aligned.
module lsu_mem_master #(
  parameter int DW = 32,
  parameter int MEM_DEPTH = 65536,
  localparam int AW = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [31:0]   req_addr,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          wen,
  output logic [AW-1:0] w_addr_o,
  output logic [DW-1:0] w_data_o,
  output logic          ren,
  output logic [AW-1:0] r_addr_o,
  input  logic [DW-1:0] r_data_i
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t        state, state_next;
  logic          lat_we, lat_uns;
  logic [1:0]    lat_size, lat_off;
  logic [AW-1:0] lat_word;
  logic [DW-1:0] lat_wdata, merge_q, rdata_q;
  logic          err_q;
  logic          req_misaligned, req_bad;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:AW+2];

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_misaligned = (req_size == 2'd1 && req_addr[0]) ||
                          (req_size == 2'd2 && req_addr[1:0] != 2'b00);
`else
  assign req_misaligned = 1'b0;
`endif

  assign req_bad = (req_size == 2'd3) || req_misaligned;

  // Sub-word lanes are always taken from the force-aligned offset; trapping builds never get here misaligned.
  function automatic logic [DW-1:0] lane_extract(input logic [DW-1:0] word, input logic [1:0] size,
                                                 input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (size)
      2'd0:    lane_extract = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'd1:    lane_extract = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: lane_extract = word;
    endcase
  endfunction

  function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic [DW-1:0] wdata);
    logic [DW-1:0] m;
    m = word;
    case (size)
      2'd0:    m[{off, 3'b000} +: 8] = wdata[7:0];
      2'd1:    m[{off[1], 4'b0000} +: 16] = wdata[15:0];
      default: m = wdata;
    endcase
    return m;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    ren        = 1'b0;
    wen        = 1'b0;
    r_addr_o   = '0;
    w_addr_o   = '0;
    w_data_o   = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_bad)                              state_next = RESP;
          else if (req_we && req_size == 2'd2)      state_next = WR;
          else                                      state_next = RD;
        end
      end
      RD: begin
        ren        = 1'b1;
        r_addr_o   = lat_word;
        state_next = lat_we ? WR : RESP;
      end
      WR: begin
        wen        = 1'b1;
        w_addr_o   = lat_word;
        w_data_o   = (lat_size == 2'd2) ? lat_wdata : merge_q;
        state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch and result capture; accept happens whenever IDLE sees req_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we    <= 1'b0;
      lat_uns   <= 1'b0;
      lat_size  <= 2'd0;
      lat_off   <= 2'd0;
      lat_word  <= '0;
      lat_wdata <= '0;
      merge_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_we    <= req_we;
            lat_uns   <= req_unsigned;
            lat_size  <= req_size;
            lat_off   <= req_addr[1:0];
            lat_word  <= req_addr[AW+1:2];
            lat_wdata <= req_wdata;
            rdata_q   <= '0;
            err_q     <= req_bad;
          end
        end
        RD: begin
          if (lat_we) merge_q <= lane_merge(r_data_i, lat_size, lat_off, lat_wdata);
          else        rdata_q <= lane_extract(r_data_i, lat_size, lat_off, lat_uns);
        end
        default: ;
      endcase
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: directed vector table, backpressure/reset sequences, random ops vs a byte-level model.
// Honours LSU_MISALIGN_TRAP_EN the same way as the design build.
module tb_lsu_mem_master;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_we, req_unsigned;
  logic [31:0]   req_addr, req_wdata;
  logic [1:0]    req_size;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [31:0]   rsp_rdata;
  logic          wen, ren;
  logic [AW-1:0] w_addr_o, r_addr_o;
  logic [31:0]   w_data_o, r_data_i;

  logic [31:0] ram [0:65535];
  int          wen_total = 0;
  int          checks = 0;
  int          errors = 0;

  lsu_mem_master dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wen(wen), .w_addr_o(w_addr_o), .w_data_o(w_data_o),
    .ren(ren), .r_addr_o(r_addr_o), .r_data_i(r_data_i)
  );

  always #5 clk = ~clk;

  // Word RAM behaving like the real data port: combinational read, registered write.
  assign r_data_i = ram[r_addr_o];
  always @(posedge clk) begin
    if (wen) begin
      ram[w_addr_o] <= w_data_o;
      wen_total     <= wen_total + 1;
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_ren;
    int          exp_wen;
    logic [15:0] exp_waddr;
    logic [31:0] exp_wdata;
  } vec_t;

  function automatic vec_t mk(logic we, logic [31:0] addr, logic [1:0] size, logic uns, logic [31:0] wdata,
                              logic [31:0] er, logic ee, int el, int eren, int ewen,
                              logic [15:0] ewa, logic [31:0] ewd);
    vec_t v;
    v.we = we; v.addr = addr; v.size = size; v.uns = uns; v.wdata = wdata;
    v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el; v.exp_ren = eren; v.exp_wen = ewen;
    v.exp_waddr = ewa; v.exp_wdata = ewd;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one request, watches the RAM port until the response, then consumes it.
  task automatic apply_stimulus(input logic we, input logic [31:0] addr, input logic [1:0] size,
                                input logic uns, input logic [31:0] wdata,
                                output logic [31:0] rdata, output logic err, output int lat,
                                output int ren_n, output int wen_n,
                                output logic [15:0] waddr, output logic [31:0] wdata_seen);
    rdata = '0; err = 1'b0; lat = -1; ren_n = 0; wen_n = 0; waddr = '0; wdata_seen = '0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (ren) ren_n++;
      if (wen) begin
        wen_n++;
        waddr = w_addr_o;
        wdata_seen = w_data_o;
      end
      if (rsp_valid) begin
        lat = cyc;
        rdata = rsp_rdata;
        err = rsp_err;
        break;
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  vec_t        vecs[16];
  logic [7:0]  refb[64];
  logic [31:0] got_rdata, got_wdata, exp_val, hold_rdata;
  logic [15:0] got_waddr;
  logic        got_err;
  int          got_lat, got_ren, got_wen, wen_before;

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 32'h0;
    for (int i = 0; i < 64; i++) refb[i] = 8'h0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
    req_unsigned = 1'b0; req_wdata = '0; rsp_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset req_ready", {31'b0, req_ready}, 32'd1);
    check_output("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check_output("reset ren/wen", {30'b0, ren, wen}, 32'd0);
    check_output("reset addrs", {w_addr_o, r_addr_o}, 32'd0);
    check_output("reset w_data", w_data_o, 32'd0);
    check_output("reset rsp_rdata", rsp_rdata, 32'd0);
    check_output("reset rsp_err", {31'b0, rsp_err}, 32'd0);
    rst_n = 1'b1;

    vecs[0]  = mk(1, 32'h100, 2, 0, 32'hDEADBEEF, 32'h0,        0, 2, 0, 1, 16'h40, 32'hDEADBEEF);
    vecs[1]  = mk(0, 32'h100, 2, 0, 32'h0,        32'hDEADBEEF, 0, 2, 1, 0, 16'h0,  32'h0);
    vecs[2]  = mk(1, 32'h101, 0, 0, 32'h000000AA, 32'h0,        0, 3, 1, 1, 16'h40, 32'hDEADAAEF);
    vecs[3]  = mk(0, 32'h100, 2, 0, 32'h0,        32'hDEADAAEF, 0, 2, 1, 0, 16'h0,  32'h0);
    vecs[4]  = mk(0, 32'h101, 0, 0, 32'h0,        32'hFFFFFFAA, 0, 2, 1, 0, 16'h0,  32'h0);
    vecs[5]  = mk(0, 32'h101, 0, 1, 32'h0,        32'h000000AA, 0, 2, 1, 0, 16'h0,  32'h0);
    vecs[6]  = mk(0, 32'h102, 1, 0, 32'h0,        32'hFFFFDEAD, 0, 2, 1, 0, 16'h0,  32'h0);
    vecs[7]  = mk(0, 32'h102, 1, 1, 32'h0,        32'h0000DEAD, 0, 2, 1, 0, 16'h0,  32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[8]  = mk(0, 32'h102, 2, 0, 32'h0,        32'h0,        1, 1, 0, 0, 16'h0,  32'h0);
    vecs[12] = mk(0, 32'h103, 1, 0, 32'h0,        32'h0,        1, 1, 0, 0, 16'h0,  32'h0);
    vecs[13] = mk(1, 32'h10A, 2, 0, 32'h55667788, 32'h0,        1, 1, 0, 0, 16'h0,  32'h0);
    vecs[14] = mk(0, 32'h108, 2, 0, 32'h0,        32'h0,        0, 2, 1, 0, 16'h0,  32'h0);
`else
    vecs[8]  = mk(0, 32'h102, 2, 0, 32'h0,        32'hDEADAAEF, 0, 2, 1, 0, 16'h0,  32'h0);
    vecs[12] = mk(0, 32'h103, 1, 0, 32'h0,        32'hFFFFDEAD, 0, 2, 1, 0, 16'h0,  32'h0);
    vecs[13] = mk(1, 32'h10A, 2, 0, 32'h55667788, 32'h0,        0, 2, 0, 1, 16'h42, 32'h55667788);
    vecs[14] = mk(0, 32'h108, 2, 0, 32'h0,        32'h55667788, 0, 2, 1, 0, 16'h0,  32'h0);
`endif
    vecs[9]  = mk(0, 32'h100, 3, 0, 32'h0,        32'h0,        1, 1, 0, 0, 16'h0,  32'h0);
    vecs[10] = mk(1, 32'h104, 3, 0, 32'hFFFFFFFF, 32'h0,        1, 1, 0, 0, 16'h0,  32'h0);
    vecs[11] = mk(1, 32'h106, 1, 0, 32'hCAFE1234, 32'h0,        0, 3, 1, 1, 16'h41, 32'h12340000);
    vecs[15] = mk(0, 32'h103, 0, 0, 32'h0,        32'hFFFFFFDE, 0, 2, 1, 0, 16'h0,  32'h0);

    for (int i = 0; i < 16; i++) begin
      apply_stimulus(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata,
                     got_rdata, got_err, got_lat, got_ren, got_wen, got_waddr, got_wdata);
      check_output($sformatf("vec%0d rdata", i), got_rdata, vecs[i].exp_rdata);
      check_output($sformatf("vec%0d err", i), {31'b0, got_err}, {31'b0, vecs[i].exp_err});
      check_output($sformatf("vec%0d latency", i), got_lat, vecs[i].exp_lat);
      check_output($sformatf("vec%0d ren cycles", i), got_ren, vecs[i].exp_ren);
      check_output($sformatf("vec%0d wen cycles", i), got_wen, vecs[i].exp_wen);
      if (vecs[i].exp_wen != 0) begin
        check_output($sformatf("vec%0d w_addr", i), {16'h0, got_waddr}, {16'h0, vecs[i].exp_waddr});
        check_output($sformatf("vec%0d w_data", i), got_wdata, vecs[i].exp_wdata);
      end
    end

    // Response backpressure: three stalled cycles with the response held and the RAM idle.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h100; req_size = 2'd2; req_unsigned = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    got_lat = -1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got_lat = cyc;
        break;
      end
    end
    check_output("stall latency", got_lat, 32'd2);
    hold_rdata = 32'hDEADAAEF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_output("stall rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check_output("stall rsp_rdata", rsp_rdata, hold_rdata);
      check_output("stall req_ready/ren/wen", {29'b0, req_ready, ren, wen}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check_output("stall release req_ready", {31'b0, req_ready}, 32'd1);
    check_output("stall release rsp_valid", {31'b0, rsp_valid}, 32'd0);

    // Reset while the SH read phase is in flight: the write must never happen.
    wen_before = wen_total;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h104; req_size = 2'd1; req_wdata = 32'h0000BEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check_output("abort in RD ren", {31'b0, ren}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_output("abort during reset outputs", {29'b0, rsp_valid, ren, wen}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_output("abort after release", {29'b0, req_ready, rsp_valid, wen}, 32'h4);
    end
    check_output("abort wen count", wen_total, wen_before);
    check_output("abort word 0x41", ram[16'h41], 32'h12340000);

    // Random traffic in a 64-byte window, checked against a byte-array model.
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a, wd;
      logic [1:0]  sz, off;
      logic        we, uns, e_err;
      int          ea, nb, e_lat;
      a   = 32'h800 + $urandom_range(0, 63);
      sz  = 2'($urandom_range(0, 3));
      if (sz == 2'd3 && ($urandom % 2) == 0) sz = 2'd2;
      we  = 1'($urandom % 2);
      uns = 1'($urandom % 2);
      wd  = $urandom;
      off = a[1:0];
      e_err = (sz == 2'd3);
`ifdef LSU_MISALIGN_TRAP_EN
      if ((sz == 2'd1 && off[0]) || (sz == 2'd2 && off != 2'b00)) e_err = 1'b1;
`endif
      ea = int'(a) - 32'h800;
      if (sz == 2'd1) ea = ea - (ea % 2);
      if (sz == 2'd2) ea = ea - (ea % 4);
      nb = 1 << sz;
      exp_val = 32'h0;
      if (e_err) e_lat = 1;
      else if (we) begin
        e_lat = (sz == 2'd2) ? 2 : 3;
        for (int b = 0; b < nb; b++) refb[ea + b] = 8'(wd >> (8 * b));
      end else begin
        e_lat = 2;
        for (int b = 0; b < nb; b++) exp_val = exp_val | (32'(refb[ea + b]) << (8 * b));
        if (!uns && sz == 2'd0 && exp_val[7])  exp_val = exp_val | 32'hFFFFFF00;
        if (!uns && sz == 2'd1 && exp_val[15]) exp_val = exp_val | 32'hFFFF0000;
      end
      apply_stimulus(we, a, sz, uns, wd, got_rdata, got_err, got_lat, got_ren, got_wen, got_waddr, got_wdata);
      check_output($sformatf("rand%0d rdata a=%h sz=%0d we=%0d", n, a, sz, we), got_rdata, exp_val);
      check_output($sformatf("rand%0d err", n), {31'b0, got_err}, {31'b0, e_err});
      check_output($sformatf("rand%0d latency", n), got_lat, e_lat);
    end

    for (int w = 0; w < 16; w++) begin
      exp_val = {refb[4*w+3], refb[4*w+2], refb[4*w+1], refb[4*w]};
      apply_stimulus(1'b0, 32'h800 + 32'(4 * w), 2'd2, 1'b0, 32'h0,
                     got_rdata, got_err, got_lat, got_ren, got_wen, got_waddr, got_wdata);
      check_output($sformatf("sweep word %0d", w), got_rdata, exp_val);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
